// File: rtl/l0_feed_ctrl_pkg.sv
// Shared types and constants for the L0 feed sequencer.
package l0_feed_ctrl_pkg;

    localparam int unsigned ROW          = 8;
    localparam int unsigned L0_DEPTH     = 64;
    localparam int unsigned SRAM_ADDR_BW = 11;
    localparam int unsigned CNT_BW       = 7;
    localparam int unsigned SRAM_RD_LAT  = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } feed_state_e;

endpackage

// File: rtl/l0_skew_gen.sv
// Diagonal read-enable pattern: row i reads while i <= d < i+n.
module l0_skew_gen
    import l0_feed_ctrl_pkg::*;
#(
    parameter int unsigned row    = ROW,
    parameter int unsigned cnt_bw = CNT_BW
) (
    input  logic [cnt_bw-1:0] d,
    input  logic [cnt_bw-1:0] n,
    input  logic              en,
    output logic [row-1:0]    rd_en
);

    // One window comparison per row; n+i never exceeds depth+row-1.
    always_comb begin
        rd_en = '0;
        for (int unsigned i = 0; i < row; i++) begin
            if (en && (d >= cnt_bw'(i)) && (d < n + cnt_bw'(i))) begin
                rd_en[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/l0_feed_ctrl.sv
// L0 input-buffer sequencer: fills L0 from activation SRAM, then drains it
// with per-row skewed read enables for the systolic array.
module l0_feed_ctrl
    import l0_feed_ctrl_pkg::*;
#(
    parameter int unsigned row     = ROW,
    parameter int unsigned addr_bw = SRAM_ADDR_BW,
    parameter int unsigned depth   = L0_DEPTH,
    parameter int unsigned cnt_bw  = CNT_BW
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [addr_bw-1:0] base_addr,
    input  logic [cnt_bw-1:0]  num_vec,
    input  logic               array_stall,
    input  logic               l0_full,
    output logic               sram_cen,
    output logic [addr_bw-1:0] sram_addr,
    output logic               l0_wr,
    output logic [row-1:0]     l0_rd_en,
    output logic               busy,
    output logic               done,
    output logic               err
);

    feed_state_e        state_q, state_d;
    logic [cnt_bw-1:0]  n_q, n_d;
    logic [cnt_bw-1:0]  rd_cnt_q, rd_cnt_d;
    logic [cnt_bw-1:0]  wr_cnt_q, wr_cnt_d;
    logic [cnt_bw-1:0]  dn_q, dn_d;
    logic               sram_cen_q, sram_cen_d;
    logic [addr_bw-1:0] sram_addr_q, sram_addr_d;
    logic               l0_wr_q, l0_wr_d;
    logic [row-1:0]     rd_en_q, rd_en_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic [cnt_bw-1:0]  drain_len;
    logic [cnt_bw-1:0]  skew_d;
    logic               skew_en;
    logic               drain_enter;
    logic               drain_stay;
    logic [row-1:0]     skew_rd_en;

    // Select the drain step shown next cycle. Enables are registered, so the
    // stall seen this cycle blanks next cycle's enables and holds the step.
    always_comb begin
        drain_len   = n_q + cnt_bw'(row - 1);
        drain_enter = (state_q == ST_LOAD) && l0_wr_q && (wr_cnt_q + cnt_bw'(1) == n_q);
        drain_stay  = (state_q == ST_DRAIN) && (dn_q != drain_len);
        skew_d      = drain_enter ? '0 : dn_q;
        skew_en     = (drain_enter || drain_stay) && !array_stall;
    end

    l0_skew_gen #(
        .row    (row),
        .cnt_bw (cnt_bw)
    ) u_skew (
        .d     (skew_d),
        .n     (n_q),
        .en    (skew_en),
        .rd_en (skew_rd_en)
    );

    // Next-state and next-output logic; every output is a flop.
    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        rd_cnt_d    = rd_cnt_q;
        wr_cnt_d    = wr_cnt_q;
        dn_d        = dn_q;
        sram_cen_d  = 1'b1;
        sram_addr_d = sram_addr_q;
        l0_wr_d     = 1'b0;
        rd_en_d     = skew_rd_en;
        done_d      = 1'b0;
        err_d       = err_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    n_d   = num_vec;
                    err_d = 1'b0;
                    if (num_vec == '0) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else if (num_vec > cnt_bw'(depth)) begin
                        err_d = 1'b1;
                    end else begin
                        state_d     = ST_LOAD;
                        sram_cen_d  = 1'b0;
                        sram_addr_d = base_addr;
                        rd_cnt_d    = cnt_bw'(1);
                        wr_cnt_d    = '0;
                    end
                end
            end
            ST_LOAD: begin
                // SRAM data returns one cycle after the read is issued.
                l0_wr_d = !sram_cen_q;
                if (rd_cnt_q < n_q) begin
                    sram_cen_d  = 1'b0;
                    sram_addr_d = sram_addr_q + addr_bw'(1);
                    rd_cnt_d    = rd_cnt_q + cnt_bw'(1);
                end
                if (l0_wr_q) begin
                    wr_cnt_d = wr_cnt_q + cnt_bw'(1);
                    if (l0_full) begin
                        err_d = 1'b1;
                    end
                end
                if (drain_enter) begin
                    state_d = ST_DRAIN;
                    dn_d    = cnt_bw'(skew_en);
                end
            end
            ST_DRAIN: begin
                if (drain_stay) begin
                    dn_d = dn_q + cnt_bw'(skew_en);
                end else begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_LOAD) || (state_d == ST_DRAIN);
    end

    // State, counter and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            n_q         <= '0;
            rd_cnt_q    <= '0;
            wr_cnt_q    <= '0;
            dn_q        <= '0;
            sram_cen_q  <= 1'b1;
            sram_addr_q <= '0;
            l0_wr_q     <= 1'b0;
            rd_en_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            rd_cnt_q    <= rd_cnt_d;
            wr_cnt_q    <= wr_cnt_d;
            dn_q        <= dn_d;
            sram_cen_q  <= sram_cen_d;
            sram_addr_q <= sram_addr_d;
            l0_wr_q     <= l0_wr_d;
            rd_en_q     <= rd_en_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign sram_cen  = sram_cen_q;
    assign sram_addr = sram_addr_q;
    assign l0_wr     = l0_wr_q;
    assign l0_rd_en  = rd_en_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_l0_feed_ctrl.sv
// Directed, table-driven bench for l0_feed_ctrl (row=8, depth=64).
// Cycle 0 is the cycle in which start is presented.
module tb_l0_feed_ctrl;

    localparam int MAXC = 160;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [10:0] base_addr = '0;
    logic [6:0]  num_vec = '0;
    logic        array_stall = 1'b0;
    logic        l0_full = 1'b0;
    logic        sram_cen;
    logic [10:0] sram_addr;
    logic        l0_wr;
    logic [7:0]  l0_rd_en;
    logic        busy;
    logic        done;
    logic        err;

    always #5 clk = ~clk;

    l0_feed_ctrl #(
        .row     (8),
        .addr_bw (11),
        .depth   (64),
        .cnt_bw  (7)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .base_addr   (base_addr),
        .num_vec     (num_vec),
        .array_stall (array_stall),
        .l0_full     (l0_full),
        .sram_cen    (sram_cen),
        .sram_addr   (sram_addr),
        .l0_wr       (l0_wr),
        .l0_rd_en    (l0_rd_en),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    typedef struct {
        int base; int n;
        int stall_at; int stall_len;
        int start_a; int start_b; int start_c;
        int full_cyc; int rst_cyc;
        int e_done; int e_reads; int e_writes; int e_rows;
        int e_rd0; int e_rd7; int e_frd; int e_fwr;
        int e_last; int e_err;
    } tile_t;

    int n_pass = 0;
    int n_total = 0;

    int o_done_cyc, o_done_cnt, o_reads, o_writes, o_frd, o_fwr, o_rd0, o_rd7;
    int o_last, o_bad_addr, o_stall_bad, o_busy, o_err, o_err_c0, o_err_c1, o_post;
    int o_rows[8];
    logic [23:0] o_snap;

    tile_t tv[9];

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic tile_t mk(input int base, input int n, input int sat, input int slen,
                                 input int sa, input int sb, input int sc, input int fc, input int rc,
                                 input int ed, input int er, input int ew, input int erow,
                                 input int e0, input int e7, input int efr, input int efw,
                                 input int el, input int ee);
        tile_t t;
        t.base = base; t.n = n; t.stall_at = sat; t.stall_len = slen;
        t.start_a = sa; t.start_b = sb; t.start_c = sc; t.full_cyc = fc; t.rst_cyc = rc;
        t.e_done = ed; t.e_reads = er; t.e_writes = ew; t.e_rows = erow;
        t.e_rd0 = e0; t.e_rd7 = e7; t.e_frd = efr; t.e_fwr = efw; t.e_last = el; t.e_err = ee;
        return t;
    endfunction

    task automatic do_reset(input string tag);
        @(posedge clk); #1;
        reset = 1'b1; start = 1'b0; array_stall = 1'b0; l0_full = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check(tag, {sram_cen, sram_addr, l0_wr, l0_rd_en, busy, done, err}, 24'h800000);
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic run_tile(input tile_t t);
        logic [10:0] exp_a;
        o_done_cyc = -1; o_done_cnt = 0; o_reads = 0; o_writes = 0; o_frd = -1; o_fwr = -1;
        o_rd0 = -1; o_rd7 = -1; o_last = 0; o_bad_addr = 0; o_stall_bad = 0; o_busy = 0;
        o_err = 0; o_err_c0 = 0; o_err_c1 = 0; o_post = 0; o_snap = '1;
        for (int r = 0; r < 8; r++) o_rows[r] = 0;
        @(posedge clk); #1;
        base_addr = 11'(t.base); num_vec = 7'(t.n); start = 1'b1;
        array_stall = 1'b0; l0_full = 1'b0;
        for (int c = 0; c < MAXC; c++) begin
            @(negedge clk);
            if (c == 0) o_err_c0 = err;
            if (c == 1) o_err_c1 = err;
            if (t.rst_cyc >= 0 && c > t.rst_cyc) begin
                if (c == t.rst_cyc + 1)
                    o_snap = {sram_cen, sram_addr, l0_wr, l0_rd_en, busy, done, err};
                if (!sram_cen || l0_wr || l0_rd_en != 8'h00 || busy || done) o_post++;
                if (c == t.rst_cyc + 4) break;
            end else begin
                if (!sram_cen) begin
                    exp_a = 11'(t.base) + 11'(o_reads);
                    if (o_reads == 0) o_frd = c;
                    if (sram_addr != exp_a) o_bad_addr++;
                    o_last = int'(sram_addr);
                    o_reads++;
                end
                if (l0_wr) begin
                    if (o_writes == 0) o_fwr = c;
                    o_writes++;
                end
                for (int r = 0; r < 8; r++) if (l0_rd_en[r]) o_rows[r]++;
                if (l0_rd_en[0] && o_rd0 < 0) o_rd0 = c;
                if (l0_rd_en[7] && o_rd7 < 0) o_rd7 = c;
                if (t.stall_len > 0 && c > t.stall_at && c <= t.stall_at + t.stall_len
                    && l0_rd_en != 8'h00) o_stall_bad++;
                if (busy) o_busy++;
                if (done) begin
                    if (o_done_cyc < 0) o_done_cyc = c;
                    o_done_cnt++;
                end
                o_err = int'(err);
                if (o_done_cyc >= 0 && c >= o_done_cyc + 2) break;
            end
            @(posedge clk); #1;
            start = (c + 1 == t.start_a) || (c + 1 == t.start_b) || (c + 1 == t.start_c);
            base_addr = ~11'(t.base);
            num_vec = 7'd9;
            array_stall = (t.stall_len > 0) && (c + 1 >= t.stall_at) && (c + 1 < t.stall_at + t.stall_len);
            l0_full = (c + 1 == t.full_cyc);
            reset = (c + 1 == t.rst_cyc);
        end
        start = 1'b0; array_stall = 1'b0; l0_full = 1'b0; reset = 1'b0;
    endtask

    task automatic compare_all(input tile_t t, input string tag);
        check({tag, ".done_cyc"}, o_done_cyc, t.e_done);
        check({tag, ".done_cnt"}, o_done_cnt, (t.e_done >= 0) ? 1 : 0);
        check({tag, ".reads"}, o_reads, t.e_reads);
        check({tag, ".writes"}, o_writes, t.e_writes);
        check({tag, ".first_read"}, o_frd, t.e_frd);
        check({tag, ".first_write"}, o_fwr, t.e_fwr);
        check({tag, ".rd0_start"}, o_rd0, t.e_rd0);
        check({tag, ".rd7_start"}, o_rd7, t.e_rd7);
        check({tag, ".last_addr"}, o_last, t.e_last);
        check({tag, ".addr_seq_errs"}, o_bad_addr, 0);
        check({tag, ".stall_window_rd"}, o_stall_bad, 0);
        check({tag, ".busy_cycles"}, o_busy, (t.e_done > 0) ? t.e_done - 1 : 0);
        check({tag, ".err"}, o_err, t.e_err);
        for (int r = 0; r < 8; r++)
            check($sformatf("%s.row%0d_pulses", tag, r), o_rows[r], t.e_rows);
    endtask

    initial begin
        do_reset("reset_init");

        //            base     n   stall   starts      full rst  done rd  wr rows rd0 rd7 frd fwr last    err
        tv[0] = mk(11'h010,  4, -1, 0, -1, -1, -1, -1, -1,  17,  4,  4,  4,  6, 13, 1, 2, 'h013, 0);
        tv[1] = mk(11'h040,  4,  8, 3, -1, -1, -1, -1, -1,  20,  4,  4,  4,  6, 16, 1, 2, 'h043, 0);
        tv[2] = mk(11'h7FE,  4, -1, 0, -1, -1, -1, -1, -1,  17,  4,  4,  4,  6, 13, 1, 2, 'h001, 0);
        tv[3] = mk(11'h100,  0, -1, 0, -1, -1, -1, -1, -1,   1,  0,  0,  0, -1, -1,-1,-1, 0,     0);
        tv[4] = mk(11'h100, 65, -1, 0, -1, -1, -1, -1, -1,  -1,  0,  0,  0, -1, -1,-1,-1, 0,     1);
        tv[5] = mk(11'h200, 64, -1, 0, -1, -1, -1, -1, -1, 137, 64, 64, 64, 66, 73, 1, 2, 'h23F, 0);
        tv[6] = mk(11'h555,  1, -1, 0, -1, -1, -1, -1, -1,  11,  1,  1,  1,  3, 10, 1, 2, 'h555, 0);
        tv[7] = mk(11'h020,  4, -1, 0,  2,  8, 17, -1, -1,  17,  4,  4,  4,  6, 13, 1, 2, 'h023, 0);
        tv[8] = mk(11'h030,  4, -1, 0, -1, -1, -1,  3, -1,  17,  4,  4,  4,  6, 13, 1, 2, 'h033, 1);

        for (int i = 0; i < 9; i++) begin
            if (i > 0) do_reset($sformatf("reset_before_v%0d", i));
            run_tile(tv[i]);
            compare_all(tv[i], $sformatf("v%0d", i));
        end

        // err from the l0_full record stays set while idle, clears on next accepted start.
        repeat (3) @(negedge clk);
        check("err_sticky_idle", err, 1);
        run_tile(mk(11'h000, 2, -1, 0, -1, -1, -1, -1, -1, 13, 2, 2, 2, 4, 11, 1, 2, 'h001, 0));
        check("err_at_accept_cycle", o_err_c0, 1);
        check("err_cleared_after_accept", o_err_c1, 0);
        check("err_clear_tile.done_cyc", o_done_cyc, 13);

        // Reset in the middle of LOAD.
        do_reset("reset_before_midload");
        run_tile(mk(11'h300, 8, -1, 0, -1, -1, -1, -1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        check("midload.reset_values", o_snap, 24'h800000);
        check("midload.post_reset_activity", o_post, 0);
        check("midload.reads_before_reset", o_reads, 3);
        run_tile(mk(11'h0AA, 2, -1, 0, -1, -1, -1, -1, -1, 13, 2, 2, 2, 4, 11, 1, 2, 'h0AB, 0));
        compare_all(mk(11'h0AA, 2, -1, 0, -1, -1, -1, -1, -1, 13, 2, 2, 2, 4, 11, 1, 2, 'h0AB, 0),
                    "after_midload");

        // Reset in the middle of DRAIN.
        run_tile(mk(11'h310, 4, -1, 0, -1, -1, -1, -1, 10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        check("middrain.reset_values", o_snap, 24'h800000);
        check("middrain.post_reset_activity", o_post, 0);
        check("middrain.writes_before_reset", o_writes, 4);
        run_tile(mk(11'h0AA, 2, -1, 0, -1, -1, -1, -1, -1, 13, 2, 2, 2, 4, 11, 1, 2, 'h0AB, 0));
        compare_all(mk(11'h0AA, 2, -1, 0, -1, -1, -1, -1, -1, 13, 2, 2, 2, 4, 11, 1, 2, 'h0AB, 0),
                    "after_middrain");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
